// File: rtl/controller_sequencer.sv
// ---------------------------------------------------------------------------
// controller_sequencer
//
// SAP-1 controller/sequencer. A six-state one-hot ring counter (T1..T6) steps
// through fetch (T1..T3) and execute (T4..T6). A Moore microcode decoder
// turns the ring state, the IR opcode and the halted flag into every
// datapath control strobe. HLT freezes the ring at T4 until clr_n.
//
// Build option: define SEQ_EARLY_END_EN to return to T1 straight after the
// last active execute state (LDA 5 clocks, ADD/SUB 6, OUT/NOP 4). Without
// it every non-HLT instruction takes the full 6 clocks. Microcode per state
// is the same in both builds.
//
// Ports:
//   clk      in   system clock, rising edge
//   clr_n    in   asynchronous active-low reset
//   opcode   in   [3:0] IR upper nibble, valid from T4 onward
//   cp ep lm ce li ei la ea su eu lb lo
//            out  datapath control strobes (eu: 0 add, 1 subtract)
//   hlt      out  machine halted
//   t_state  out  [5:0] one-hot ring state, bit0 = T1
// ---------------------------------------------------------------------------
module controller_sequencer (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [3:0] opcode,
    output logic       cp,
    output logic       ep,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb,
    output logic       lo,
    output logic       hlt,
    output logic [5:0] t_state
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } ring_e;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    ring_e state_q, state_d;
    logic  halted_q, halted_d;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= T1;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        // next state
        state_d  = state_q;
        halted_d = halted_q;
        if (!halted_q) begin
            case (state_q)
                T1: state_d = T2;
                T2: state_d = T3;
                T3: state_d = T4;
                T4: begin
                    if (opcode == OP_HLT) begin
                        // ring stays at T4; the flag alone freezes it
                        halted_d = 1'b1;
                    end else begin
`ifdef SEQ_EARLY_END_EN
                        if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB)
                            state_d = T5;
                        else
                            state_d = T1;
`else
                        state_d = T5;
`endif
                    end
                end
                T5: begin
`ifdef SEQ_EARLY_END_EN
                    state_d = (opcode == OP_LDA) ? T1 : T6;
`else
                    state_d = T6;
`endif
                end
                T6:      state_d = T1;
                default: state_d = T1;
            endcase
        end

        // microcode outputs
        cp  = 1'b0;
        ep  = 1'b0;
        lm  = 1'b0;
        ce  = 1'b0;
        li  = 1'b0;
        ei  = 1'b0;
        la  = 1'b0;
        ea  = 1'b0;
        su  = 1'b0;
        eu  = 1'b0;
        lb  = 1'b0;
        lo  = 1'b0;
        hlt = halted_q;
        if (!halted_q) begin
            case (state_q)
                T1: begin
                    ep = 1'b1;
                    lm = 1'b1;
                end
                T2: cp = 1'b1;
                T3: begin
                    ce = 1'b1;
                    li = 1'b1;
                end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ei = 1'b1;
                            lm = 1'b1;
                        end
                        OP_OUT: begin
                            ea = 1'b1;
                            lo = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA: begin
                            ce = 1'b1;
                            la = 1'b1;
                        end
                        OP_ADD: begin
                            ce = 1'b1;
                            lb = 1'b1;
                        end
                        OP_SUB: begin
                            // eu is set a state early so the ALU settles
                            ce = 1'b1;
                            lb = 1'b1;
                            eu = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD: begin
                            su = 1'b1;
                            la = 1'b1;
                        end
                        OP_SUB: begin
                            su = 1'b1;
                            la = 1'b1;
                            eu = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign t_state = state_q;

endmodule

// File: tb/tb_controller_sequencer.sv
module tb_controller_sequencer;

    logic       clk;
    logic       clr_n;
    logic [3:0] opcode;
    logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
    logic [5:0] t_state;

    controller_sequencer dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .opcode  (opcode),
        .cp      (cp),
        .ep      (ep),
        .lm      (lm),
        .ce      (ce),
        .li      (li),
        .ei      (ei),
        .la      (la),
        .ea      (ea),
        .su      (su),
        .eu      (eu),
        .lb      (lb),
        .lo      (lo),
        .hlt     (hlt),
        .t_state (t_state)
    );

    // control vector bit positions
    localparam int CP = 12, EP = 11, LM = 10, CE = 9, LI = 8, EI = 7, LA = 6;
    localparam int EA = 5, SU = 4, EU = 3, LB = 2, LO = 1, HLT = 0;

    localparam logic [3:0] LDA_OP = 4'b0000;
    localparam logic [3:0] ADD_OP = 4'b0001;
    localparam logic [3:0] SUB_OP = 4'b0010;
    localparam logic [3:0] OUT_OP = 4'b1110;
    localparam logic [3:0] HLT_OP = 4'b1111;
    localparam logic [3:0] NOP_OP = 4'b0101;

    logic [18:0] obs;
    logic [4:0]  bus;
    assign obs = {t_state, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt};
    assign bus = {ep, ce, ei, ea, su};

    logic [18:0] sb[$];
    int total  = 0;
    int passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    // expected microcode, written out from the instruction table
    function automatic logic [12:0] ucode(input int t, input logic [3:0] op);
        logic [12:0] m;
        m = '0;
        case (t)
            1: begin m[EP] = 1'b1; m[LM] = 1'b1; end
            2: m[CP] = 1'b1;
            3: begin m[CE] = 1'b1; m[LI] = 1'b1; end
            4: begin
                if (op == LDA_OP || op == ADD_OP || op == SUB_OP) begin
                    m[EI] = 1'b1; m[LM] = 1'b1;
                end else if (op == OUT_OP) begin
                    m[EA] = 1'b1; m[LO] = 1'b1;
                end
            end
            5: begin
                if (op == LDA_OP) begin m[CE] = 1'b1; m[LA] = 1'b1; end
                if (op == ADD_OP) begin m[CE] = 1'b1; m[LB] = 1'b1; end
                if (op == SUB_OP) begin m[CE] = 1'b1; m[LB] = 1'b1; m[EU] = 1'b1; end
            end
            6: begin
                if (op == ADD_OP) begin m[SU] = 1'b1; m[LA] = 1'b1; end
                if (op == SUB_OP) begin m[SU] = 1'b1; m[LA] = 1'b1; m[EU] = 1'b1; end
            end
            default: ;
        endcase
        return m;
    endfunction

    function automatic int instr_len(input logic [3:0] op);
`ifdef SEQ_EARLY_END_EN
        if (op == LDA_OP) return 5;
        if (op == ADD_OP || op == SUB_OP) return 6;
        return 4;
`else
        if (op == HLT_OP) return 4;
        return 6;
`endif
    endfunction

    function automatic logic [18:0] expect_vec(input int t, input logic [3:0] op);
        logic [5:0] oh;
        oh = 6'(1) << (t - 1);
        return {oh, ucode(t, op)};
    endfunction

    task automatic check(input string tag, input bit wait_edge);
        logic [18:0] exp;
        if (wait_edge) @(negedge clk);
        total++;
        if (sb.size() == 0) begin
            $error("FAIL %s: observed %h required <scoreboard entry>", tag, obs);
        end else begin
            exp = sb.pop_front();
            assert (obs === exp) passed++;
            else $error("FAIL %s: observed t=%b ctl=%b required t=%b ctl=%b",
                        tag, obs[18:13], obs[12:0], exp[18:13], exp[12:0]);
        end
        total++;
        assert ($countones(bus) <= 1) passed++;
        else $error("FAIL %s_bus: observed drivers %b required at most one", tag, bus);
    endtask

    task automatic run_instr(input logic [3:0] op, input int stop_at, input string name);
        int len;
        len = instr_len(op);
        for (int t = 1; t <= len && t <= stop_at; t++) begin
            if (t == 1) opcode = ~op;  // IR contents are don't-care during fetch
            if (t == 4) opcode = op;
            sb.push_back(expect_vec(t, op));
            check($sformatf("%s_T%0d", name, t), 1'b1);
        end
    endtask

    task automatic reset_pulse(input string name);
        #2 clr_n = 1'b0;
        #1;
        sb.push_back(expect_vec(1, 4'b0000));
        check(name, 1'b0);
        @(posedge clk);
        #1 clr_n = 1'b1;
    endtask

    initial begin
        clr_n  = 1'b0;
        opcode = 4'b0000;

        // reset held across clock edges
        repeat (3) @(posedge clk);
        sb.push_back(expect_vec(1, 4'b0000));
        check("reset", 1'b1);
        @(posedge clk);
        #1 clr_n = 1'b1;

        run_instr(ADD_OP, 6, "add");
        run_instr(SUB_OP, 6, "sub");
        run_instr(LDA_OP, 6, "lda");
        run_instr(NOP_OP, 6, "nop");
        run_instr(OUT_OP, 6, "out");

        // reset in the middle of ADD T5, between edges
        run_instr(ADD_OP, 5, "add_mid");
        reset_pulse("mid_reset");

        run_instr(ADD_OP, 6, "add2");
        run_instr(OUT_OP, 6, "out2");
        run_instr(HLT_OP, 4, "hlt");
        for (int i = 0; i < 20; i++) begin
            sb.push_back({6'b001000, 13'b0000000000001});
            check($sformatf("halted_%0d", i), 1'b1);
        end
        reset_pulse("halt_reset");

        // back-to-back LDA, OUT, ADD (length differs with early end)
        run_instr(LDA_OP, 6, "lda_b2b");
        run_instr(OUT_OP, 6, "out_b2b");
        run_instr(ADD_OP, 6, "add_b2b");
        run_instr(SUB_OP, 6, "sub_b2b");
        run_instr(LDA_OP, 1, "after_sub");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
